formal_mem_responder: RTL and testbench
=======================================

Name: formal_mem_responder

Overview:
- Parametrised memory-side bus model for the RiscV32Core memIF.
- Replaces the free nondeterministic mem_ready/mem_rdata drivers in formal harnesses and simulation benches.
- Provides a word-addressed backing store with byte-lane writes, a bounded, stallable response latency, out-of-range error signalling and a sticky protocol-violation checker.
- Sits between the core's memory interface and the proof module; its stall_req input is left free (rand) under formal.

Parameters:
- DATA_WIDTH, 32, bus data width; multiple of 8.
- ADDR_WIDTH, 32, bus address width.
- DEPTH_WORDS, 256, number of backing words; power of two.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; word aligned.
- MIN_LATENCY, 1, minimum cycles from request accept to ready; ≥1.
- MAX_LATENCY, 4, maximum cycles from request accept to ready; ≥MIN_LATENCY.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- mem_valid  in  1  core request valid
- mem_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored
- mem_write  in  1  1 = write, 0 = read
- mem_wdata  in  DATA_WIDTH  write data
- mem_size  in  DATA_WIDTH/8  byte-lane enable mask
- mem_ready  out  1  single-cycle response pulse
- mem_rdata  out  DATA_WIDTH  read data, valid only while mem_ready=1
- stall_req  in  1  request an extra wait cycle (free input under formal)
- bus_err  out  1  pulses with mem_ready on an out-of-range access
- proto_err  out  1  sticky protocol-violation flag
- req_count  out  32  completed transactions, saturating
- init_we  in  1  preload write strobe; honoured only while reset=1
- init_index  in  $clog2(DEPTH_WORDS)  preload word index
- init_data  in  DATA_WIDTH  preload word

Behaviour:
- Reset (synchronous, active-high): FSM→IDLE; mem_ready, bus_err, proto_err = 0; mem_rdata = 0; req_count = 0; latency counter = 0. Array contents are NOT cleared.
- Preload: while reset=1 and init_we=1, store init_data at init_index. init_we is ignored when reset=0.
- FSM states: IDLE, WAIT, RESP.
- IDLE: if mem_valid=1 at cycle t, capture addr/write/wdata/size, set cnt=1, go to WAIT. Otherwise stay in IDLE.
- WAIT: go to RESP when cnt≥MIN_LATENCY and (stall_req=0 or cnt=MAX_LATENCY). Otherwise cnt+1.
- Resulting latency: mem_ready high exactly at cycle t+L, with MIN_LATENCY≤L≤MAX_LATENCY. L=MIN_LATENCY when stall_req stays low.
- RESP (one cycle): mem_ready=1.
  - Read: mem_rdata = stored word.
  - Write: mem_rdata = 0; byte lanes with mem_size[i]=1 are committed at the clock edge ending RESP.
  - req_count+1, saturating at 32'hFFFF_FFFF.
  - Next state IDLE.
- mem_valid seen in the cycle after RESP is treated as a new request. Back-to-back accepts are therefore allowed.
- Outside RESP: mem_ready=0 and mem_rdata=0.
- Range check: in range iff addr≥BASE_ADDR and ((addr−BASE_ADDR)>>2) < DEPTH_WORDS.
  - Out of range: read returns 0, write is dropped, bus_err=1 in the RESP cycle.
- Protocol check, in WAIT and RESP: any of the following sets proto_err=1 until reset; the transaction still completes using the captured values:
  - mem_valid=0;
  - mem_addr, mem_write, mem_wdata or mem_size differs from the captured value.
- mem_size=0 on a write: no bytes change; the response is still generated.
- Reset asserted mid-transaction: the transaction is abandoned, no write is committed, and no ready is issued.
- Index arithmetic is done in ADDR_WIDTH bits; subtraction wrap-around counts as out of range via the addr≥BASE_ADDR test.

Decomposition:
- Package formal_mem_pkg: FSM state enum (IDLE/WAIT/RESP), lane-count constant DATA_WIDTH/8, and a latency-counter width function $clog2(MAX_LATENCY+1).
- Sub-module formal_mem_array:
  - DEPTH_WORDS×DATA_WIDTH storage;
  - one byte-enabled write port shared by preload and bus via a mux, with preload selected when reset=1;
  - one asynchronous read port.

Test Plan:
- Preload word 0 = 32'h0000_0013 under reset, release reset, read addr 0 with stall_req=0, MIN_LATENCY=1 → mem_ready at t+1, mem_rdata=32'h0000_0013, req_count=1.
- Write addr 0x4 wdata 32'hAABBCCDD size 4'b0011 over a word preloaded to 0, then read 0x4 → 32'h0000_CCDD.
- MIN=2, MAX=4, stall_req held 1 → ready exactly at t+4. With stall_req pulsed only at cnt=2 → ready at t+3.
- Read addr BASE_ADDR+4*DEPTH_WORDS → ready with bus_err=1, rdata=0. Write to the same address → array unchanged.
- Drop mem_valid in the WAIT cycle → proto_err=1 and stays 1 across later clean transactions until reset.
- Assert reset during WAIT of a write to 0x8 → no ready pulse, word 0x8 unchanged, req_count=0.

Source files
------------

// File: rtl/formal_mem_pkg.sv
// Shared types and sizing helpers for the formal memory responder.
package formal_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int BYTE_W            = 8;
    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_LANES         = DEF_DATA_WIDTH / BYTE_W;

    function automatic int lane_count(input int data_width);
        return data_width / BYTE_W;
    endfunction

    function automatic int lat_cnt_width(input int max_latency);
        return $clog2(max_latency + 1);
    endfunction

endpackage

// File: rtl/formal_mem_array.sv
// Word-organised backing store: one byte-enabled write port (preload or bus) and
// one asynchronous read port.
module formal_mem_array
    import formal_mem_pkg::*;
#(
    parameter int  DATA_WIDTH  = 32,
    parameter int  DEPTH_WORDS = 256,
    localparam int LANES       = lane_count(DATA_WIDTH),
    localparam int IDX_W       = $clog2(DEPTH_WORDS)
)(
    input  logic                  clock_i,
    input  logic                  preload_sel_i,
    input  logic                  init_we_i,
    input  logic [IDX_W-1:0]      init_index_i,
    input  logic [DATA_WIDTH-1:0] init_data_i,
    input  logic                  bus_we_i,
    input  logic [LANES-1:0]      bus_be_i,
    input  logic [IDX_W-1:0]      bus_index_i,
    input  logic [DATA_WIDTH-1:0] bus_data_i,
    input  logic [IDX_W-1:0]      rd_index_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

    logic                  wr_en;
    logic [LANES-1:0]      wr_be;
    logic [IDX_W-1:0]      wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;

    // While in reset only the preload path may write; bus writes are blocked.
    always_comb begin
        wr_en   = bus_we_i;
        wr_be   = bus_be_i;
        wr_idx  = bus_index_i;
        wr_data = bus_data_i;
        if (preload_sel_i) begin
            wr_en   = init_we_i;
            wr_be   = '1;
            wr_idx  = init_index_i;
            wr_data = init_data_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (wr_en) begin
            for (int b = 0; b < LANES; b++) begin
                if (wr_be[b]) begin
                    mem_q[wr_idx][b*BYTE_W +: BYTE_W] <= wr_data[b*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    assign rd_data_o = mem_q[rd_index_i];

endmodule

// File: rtl/formal_mem_responder.sv
// Memory-side bus model for the core memIF: bounded stallable latency, byte-lane
// writes, out-of-range error and a sticky protocol-violation flag.
module formal_mem_responder
    import formal_mem_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    MIN_LATENCY = 1,
    parameter int                    MAX_LATENCY = 4
)(
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           mem_valid,
    input  logic [ADDR_WIDTH-1:0]          mem_addr,
    input  logic                           mem_write,
    input  logic [DATA_WIDTH-1:0]          mem_wdata,
    input  logic [DATA_WIDTH/8-1:0]        mem_size,
    output logic                           mem_ready,
    output logic [DATA_WIDTH-1:0]          mem_rdata,
    input  logic                           stall_req,
    output logic                           bus_err,
    output logic                           proto_err,
    output logic [31:0]                    req_count,
    input  logic                           init_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] init_index,
    input  logic [DATA_WIDTH-1:0]          init_data
);

    localparam int LANES = lane_count(DATA_WIDTH);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = lat_cnt_width(MAX_LATENCY);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  proto_q, proto_d;
    logic [31:0]           count_q, count_d;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [LANES-1:0]      size_q, size_d;

    logic [CNT_W-1:0]      cnt_nx;
    logic                  go_resp;
    logic                  violation;
    logic [ADDR_WIDTH-1:0] offset;
    logic                  in_range;
    logic [IDX_W-1:0]      word_idx;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  resp;

    assign offset   = addr_q - BASE_ADDR;
    assign in_range = (addr_q >= BASE_ADDR) && ((offset >> 2) < ADDR_WIDTH'(DEPTH_WORDS));
    assign word_idx = offset[IDX_W+1:2];

    // cnt_nx is the cycle count the transaction will have reached after this
    // edge, so RESP lands exactly MIN_LATENCY..MAX_LATENCY cycles after accept.
    assign cnt_nx  = (state_q == ST_IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
    assign go_resp = (cnt_nx >= CNT_W'(MIN_LATENCY)) &&
                     (!stall_req || (cnt_nx == CNT_W'(MAX_LATENCY)));

    assign violation = !mem_valid || (mem_addr != addr_q) || (mem_write != write_q) ||
                       (mem_wdata != wdata_q) || (mem_size != size_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        proto_d = proto_q;
        count_d = count_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_valid) begin
                    addr_d  = mem_addr;
                    write_d = mem_write;
                    wdata_d = mem_wdata;
                    size_d  = mem_size;
                    cnt_d   = cnt_nx;
                    state_d = go_resp ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_nx;
                if (go_resp) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
                if (count_q != '1) begin
                    count_d = count_q + 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if ((state_q == ST_WAIT || state_q == ST_RESP) && violation) begin
            proto_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            proto_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            proto_q <= proto_d;
            count_q <= count_d;
        end
    end

    // Captured request is data only; it is meaningless outside WAIT/RESP.
    always_ff @(posedge clock) begin
        addr_q  <= addr_d;
        write_q <= write_d;
        wdata_q <= wdata_d;
        size_q  <= size_d;
    end

    formal_mem_array #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clock_i       (clock),
        .preload_sel_i (reset),
        .init_we_i     (init_we),
        .init_index_i  (init_index),
        .init_data_i   (init_data),
        .bus_we_i      ((state_q == ST_RESP) && write_q && in_range),
        .bus_be_i      (size_q),
        .bus_index_i   (word_idx),
        .bus_data_i    (wdata_q),
        .rd_index_i    (word_idx),
        .rd_data_o     (rd_word)
    );

    assign resp      = (state_q == ST_RESP) && !reset;
    assign mem_ready = resp;
    assign bus_err   = resp && !in_range;
    assign mem_rdata = (resp && !write_q && in_range) ? rd_word : '0;
    assign proto_err = proto_q;
    assign req_count = count_q;

endmodule

// File: tb/tb_formal_mem_responder.sv
// Bench for formal_mem_responder: instance A (base 0, latency 1..4) and
// instance B (base 0x1000, latency 2..4) share the request bus but not mem_valid.
module tb_formal_mem_responder;

    logic        clock, reset, valid_a, valid_b, write, stall, init_we;
    logic [31:0] addr, wdata, init_data;
    logic [3:0]  size;
    logic [7:0]  init_index;

    logic        ready_a, err_a, proto_a, ready_b, err_b, proto_b;
    logic [31:0] rdata_a, cnt_a, rdata_b, cnt_b;

    formal_mem_responder #(
        .BASE_ADDR(32'h0000_0000), .MIN_LATENCY(1), .MAX_LATENCY(4)
    ) dut_a (
        .clock(clock), .reset(reset), .mem_valid(valid_a), .mem_addr(addr),
        .mem_write(write), .mem_wdata(wdata), .mem_size(size), .mem_ready(ready_a),
        .mem_rdata(rdata_a), .stall_req(stall), .bus_err(err_a), .proto_err(proto_a),
        .req_count(cnt_a), .init_we(init_we), .init_index(init_index), .init_data(init_data)
    );

    formal_mem_responder #(
        .BASE_ADDR(32'h0000_1000), .MIN_LATENCY(2), .MAX_LATENCY(4)
    ) dut_b (
        .clock(clock), .reset(reset), .mem_valid(valid_b), .mem_addr(addr),
        .mem_write(write), .mem_wdata(wdata), .mem_size(size), .mem_ready(ready_b),
        .mem_rdata(rdata_b), .stall_req(stall), .bus_err(err_b), .proto_err(proto_b),
        .req_count(cnt_b), .init_we(init_we), .init_index(init_index), .init_data(init_data)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  lat;
    } rsp_t;
    rsp_t exp_q[$];

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  size;
        logic [7:0]  stall;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
    } vec_t;
    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Inputs are driven at the falling edge, so values set at negedge k are the
    // ones the DUT samples at the rising edge ending cycle t+k. Bit k of stall_m /
    // drop_m selects stall_req=1 / mem_valid=0 for cycle t+k.
    task automatic txn(input bit sel_b, input logic [31:0] a, input logic w,
                       input logic [31:0] d, input logic [3:0] s,
                       input logic [7:0] stall_m, input logic [7:0] drop_m,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input int exp_lat, input string name);
        rsp_t        e;
        logic [31:0] got_rd;
        logic        got_err;
        int          lat;
        bit          got;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.lat   = exp_lat[3:0];
        exp_q.push_back(e);
        @(negedge clock);
        check({name, " idle_rdata"}, sel_b ? rdata_b : rdata_a, 32'h0);
        addr  = a;
        write = w;
        wdata = d;
        size  = s;
        stall = stall_m[0];
        if (sel_b) valid_b = 1'b1; else valid_a = 1'b1;
        got     = 1'b0;
        lat     = 0;
        got_rd  = '0;
        got_err = 1'b0;
        for (int k = 1; k <= 12 && !got; k++) begin
            @(negedge clock);
            if ((sel_b ? ready_b : ready_a) === 1'b1) begin
                got     = 1'b1;
                lat     = k;
                got_rd  = sel_b ? rdata_b : rdata_a;
                got_err = sel_b ? err_b : err_a;
                stall   = 1'b0;
                if (sel_b) valid_b = 1'b1; else valid_a = 1'b1;
            end else begin
                stall = (k < 8) ? stall_m[k[2:0]] : 1'b0;
                if (sel_b) valid_b = (k < 8) ? ~drop_m[k[2:0]] : 1'b1;
                else       valid_a = (k < 8) ? ~drop_m[k[2:0]] : 1'b1;
            end
        end
        e = exp_q.pop_front();
        if (got) begin
            check({name, " rdata"}, got_rd, e.rdata);
            check({name, " bus_err"}, {31'b0, got_err}, {31'b0, e.err});
            check({name, " latency"}, 32'(lat), {28'b0, e.lat});
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: no mem_ready within 12 cycles, want latency %0d", name, e.lat);
        end
        @(posedge clock);
        #1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        write   = 1'b0;
        stall   = 1'b0;
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] d);
        @(negedge clock);
        init_we    = 1'b1;
        init_index = idx;
        init_data  = d;
    endtask

    initial begin
        reset = 1'b1; valid_a = 1'b0; valid_b = 1'b0; write = 1'b0; stall = 1'b0;
        addr = '0; wdata = '0; size = '0; init_we = 1'b0; init_index = '0; init_data = '0;

        vecs[0]  = '{32'h0000_0000, 1'b0, 32'h0,          4'b0000, 8'h00, 32'h0000_0013, 1'b0, 1};
        vecs[1]  = '{32'h0000_0004, 1'b0, 32'h0,          4'b0000, 8'h00, 32'h0000_0000, 1'b0, 1};
        vecs[2]  = '{32'h0000_0004, 1'b1, 32'hAABB_CCDD, 4'b0011, 8'h00, 32'h0000_0000, 1'b0, 1};
        vecs[3]  = '{32'h0000_0004, 1'b0, 32'h0,          4'b0000, 8'h00, 32'h0000_CCDD, 1'b0, 1};
        vecs[4]  = '{32'h0000_0004, 1'b1, 32'h1111_1111, 4'b0000, 8'h00, 32'h0000_0000, 1'b0, 1};
        vecs[5]  = '{32'h0000_0004, 1'b0, 32'h0,          4'b0000, 8'h00, 32'h0000_CCDD, 1'b0, 1};
        vecs[6]  = '{32'h0000_0004, 1'b1, 32'h9988_7766, 4'b1100, 8'h00, 32'h0000_0000, 1'b0, 1};
        vecs[7]  = '{32'h0000_0004, 1'b0, 32'h0,          4'b0000, 8'h00, 32'h9988_CCDD, 1'b0, 1};
        vecs[8]  = '{32'h0000_03FC, 1'b0, 32'h0,          4'b0000, 8'h00, 32'hDEAD_BEEF, 1'b0, 1};
        vecs[9]  = '{32'h0000_0400, 1'b0, 32'h0,          4'b0000, 8'h00, 32'h0000_0000, 1'b1, 1};
        vecs[10] = '{32'h0000_0400, 1'b1, 32'hFFFF_FFFF, 4'b1111, 8'h00, 32'h0000_0000, 1'b1, 1};
        vecs[11] = '{32'h0000_0000, 1'b0, 32'h0,          4'b0000, 8'h00, 32'h0000_0013, 1'b0, 1};
        vecs[12] = '{32'h0000_000B, 1'b0, 32'h0,          4'b0000, 8'h0F, 32'h1122_3344, 1'b0, 4};
        vecs[13] = '{32'h0000_0008, 1'b1, 32'hCAFE_F00D, 4'b1111, 8'h00, 32'h0000_0000, 1'b0, 1};
        vecs[14] = '{32'h0000_0008, 1'b0, 32'h0,          4'b0000, 8'h00, 32'hCAFE_F00D, 1'b0, 1};

        repeat (2) @(negedge clock);
        preload(8'd0,   32'h0000_0013);
        preload(8'd1,   32'h0000_0000);
        preload(8'd2,   32'h1122_3344);
        preload(8'd255, 32'hDEAD_BEEF);
        @(negedge clock);
        init_we = 1'b0;
        check("rst ready_a", {31'b0, ready_a}, 32'h0);
        check("rst bus_err_a", {31'b0, err_a}, 32'h0);
        check("rst proto_a", {31'b0, proto_a}, 32'h0);
        check("rst rdata_a", rdata_a, 32'h0);
        check("rst count_a", cnt_a, 32'h0);
        check("rst count_b", cnt_b, 32'h0);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst ready_a", {31'b0, ready_a}, 32'h0);
        init_we = 1'b1; init_index = 8'd1; init_data = 32'hBAD0_BAD0;
        @(negedge clock);
        init_we = 1'b0;

        for (int i = 0; i < 15; i++) begin
            txn(1'b0, vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].size, vecs[i].stall,
                8'h00, vecs[i].exp_rd, vecs[i].exp_err, vecs[i].exp_lat, $sformatf("vecA%0d", i));
            if (i == 0) check("count after first read", cnt_a, 32'd1);
        end
        check("count_a after table", cnt_a, 32'd15);
        check("proto_a clean", {31'b0, proto_a}, 32'h0);

        txn(1'b1, 32'h0000_1000, 1'b0, 32'h0, 4'h0, 8'h00, 8'h00, 32'h0000_0013, 1'b0, 2, "B min_lat");
        txn(1'b1, 32'h0000_1000, 1'b0, 32'h0, 4'h0, 8'hFF, 8'h00, 32'h0000_0013, 1'b0, 4, "B stall_held");
        txn(1'b1, 32'h0000_1000, 1'b0, 32'h0, 4'h0, 8'h02, 8'h00, 32'h0000_0013, 1'b0, 3, "B stall_pulse");
        txn(1'b1, 32'h0000_0FFC, 1'b0, 32'h0, 4'h0, 8'h00, 8'h00, 32'h0000_0000, 1'b1, 2, "B below_base");
        txn(1'b1, 32'h0000_1400, 1'b0, 32'h0, 4'h0, 8'h00, 8'h00, 32'h0000_0000, 1'b1, 2, "B past_end");
        check("proto_b clean", {31'b0, proto_b}, 32'h0);
        txn(1'b1, 32'h0000_1008, 1'b0, 32'h0, 4'h0, 8'h00, 8'h02, 32'h1122_3344, 1'b0, 2, "B drop_valid");
        check("proto_b set", {31'b0, proto_b}, 32'h1);
        txn(1'b1, 32'h0000_1000, 1'b0, 32'h0, 4'h0, 8'h00, 8'h00, 32'h0000_0013, 1'b0, 2, "B after_viol");
        check("proto_b sticky", {31'b0, proto_b}, 32'h1);
        check("count_b", cnt_b, 32'd7);

        // Reset lands while B is stalled in WAIT on a write to word 2.
        @(negedge clock);
        addr = 32'h0000_1008; write = 1'b1; wdata = 32'h0; size = 4'hF; stall = 1'b1; valid_b = 1'b1;
        @(negedge clock);
        check("rstmid wait ready", {31'b0, ready_b}, 32'h0);
        reset = 1'b1;
        @(negedge clock);
        check("rstmid held ready", {31'b0, ready_b}, 32'h0);
        valid_b = 1'b0; write = 1'b0; stall = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            check($sformatf("rstmid after ready %0d", c), {31'b0, ready_b}, 32'h0);
        end
        check("rstmid count_b", cnt_b, 32'h0);
        check("rstmid proto_b", {31'b0, proto_b}, 32'h0);
        check("rstmid count_a", cnt_a, 32'h0);
        txn(1'b1, 32'h0000_1008, 1'b0, 32'h0, 4'h0, 8'h00, 8'h00, 32'h1122_3344, 1'b0, 2, "B word2 intact");
        txn(1'b0, 32'h0000_0008, 1'b0, 32'h0, 4'h0, 8'h00, 8'h00, 32'hCAFE_F00D, 1'b0, 1, "A array kept");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
